// File: rtl/j1_io_pkg.sv
// Shared definitions for J1 I/O peripherals: register offsets, STATUS bit
// positions and the UART transmitter/receiver state types.
package j1_io_pkg;

  localparam logic [15:0] REG_DATA   = 16'h0000;
  localparam logic [15:0] REG_STATUS = 16'h0002;
  localparam logic [15:0] REG_DIV    = 16'h0004;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_TX_OVF    = 5;

  localparam logic [15:0] DIV_MIN = 16'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational head. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign empty  = (count_r == {(AW+1){1'b0}});
  assign full   = (count_r == CNT_FULL);
  assign pop_s  = pop & ~empty;
  assign push_s = push & (~full | pop_s);
  assign head   = mem_r[rd_ptr_r];

  // Storage write port; contents need no reset since count gates visibility.
  always_ff @(posedge sys_clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/j1_uart.sv
// Memory-mapped 8N1 UART on the J1 I/O bus: DATA/STATUS/DIV registers,
// RX and TX FIFOs, sticky error flags and a zero-default read mux.
import j1_io_pkg::*;

module j1_uart #(
  parameter logic [15:0] BASE_ADDR  = 16'hF000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o,
  output logic        rx_irq_o
);

  logic [15:0] div_r;
  logic [15:0] div_eff_s;
  logic [15:0] half_s;
  logic        sel_data_s, sel_status_s, sel_div_s;
  logic        wr_data_s, wr_status_s, wr_div_s, rd_data_s;

  logic        tx_pop_s, tx_full_s, tx_empty_s, tx_idle_s;
  logic [7:0]  tx_head_s;
  logic        rx_push_s, rx_full_s, rx_empty_s;
  logic [7:0]  rx_head_s;

  logic        rx_ovr_r, frame_err_r, tx_ovf_r;
  logic        rx_ovr_set_s, frame_set_s, tx_ovf_set_s;
  logic [15:0] status_s;

  uart_tx_state_t tx_state_r, tx_state_nxt_s;
  logic [15:0]    tx_cnt_r, tx_cnt_nxt_s;
  logic [2:0]     tx_bit_r, tx_bit_nxt_s;
  logic [7:0]     tx_shift_r, tx_shift_nxt_s;
  logic           txd_r, txd_nxt_s;

  uart_rx_state_t rx_state_r, rx_state_nxt_s;
  logic [15:0]    rx_cnt_r, rx_cnt_nxt_s;
  logic [2:0]     rx_bit_r, rx_bit_nxt_s;
  logic [7:0]     rx_shift_r, rx_shift_nxt_s;
  logic           rxd_meta_r, rxd_sync_r, rxd_prev_r;

  assign sel_data_s   = (io_addr == BASE_ADDR + REG_DATA);
  assign sel_status_s = (io_addr == BASE_ADDR + REG_STATUS);
  assign sel_div_s    = (io_addr == BASE_ADDR + REG_DIV);
  assign wr_data_s    = io_wr & sel_data_s;
  assign wr_status_s  = io_wr & sel_status_s;
  assign wr_div_s     = io_wr & sel_div_s;
  assign rd_data_s    = io_rd & sel_data_s;

  // Bit period is DIV+1; the start-bit re-sample lands (DIV+1)/2 cycles in.
  assign div_eff_s = (div_r < DIV_MIN) ? DIV_MIN : div_r;
  assign half_s    = (div_eff_s >> 1) + {15'd0, div_eff_s[0]} - 16'd1;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .push      (wr_data_s),
    .pop       (tx_pop_s),
    .din       (io_dout[7:0]),
    .head      (tx_head_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .push      (rx_push_s),
    .pop       (rd_data_s),
    .din       (rx_shift_r),
    .head      (rx_head_s),
    .full      (rx_full_s),
    .empty     (rx_empty_s)
  );

  // TX next-state: each state holds for DIV+1 cycles, txd is registered.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r;
    tx_bit_nxt_s   = tx_bit_r;
    tx_shift_nxt_s = tx_shift_r;
    txd_nxt_s      = txd_r;
    tx_pop_s       = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        txd_nxt_s = 1'b1;
        if (!tx_empty_s) begin
          tx_pop_s       = 1'b1;
          tx_shift_nxt_s = tx_head_s;
          tx_cnt_nxt_s   = div_eff_s;
          txd_nxt_s      = 1'b0;
          tx_state_nxt_s = TX_START;
        end else begin
          tx_state_nxt_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_r == 16'd0) begin
          tx_cnt_nxt_s   = div_eff_s;
          tx_bit_nxt_s   = 3'd0;
          txd_nxt_s      = tx_shift_r[0];
          tx_state_nxt_s = TX_DATA;
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == 16'd0) begin
          tx_cnt_nxt_s = div_eff_s;
          if (tx_bit_r == 3'd7) begin
            txd_nxt_s      = 1'b1;
            tx_state_nxt_s = TX_STOP;
          end else begin
            tx_bit_nxt_s   = tx_bit_r + 3'd1;
            tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
            txd_nxt_s      = tx_shift_r[1];
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == 16'd0) begin
          if (!tx_empty_s) begin
            tx_pop_s       = 1'b1;
            tx_shift_nxt_s = tx_head_s;
            tx_cnt_nxt_s   = div_eff_s;
            txd_nxt_s      = 1'b0;
            tx_state_nxt_s = TX_START;
          end else begin
            txd_nxt_s      = 1'b1;
            tx_state_nxt_s = TX_IDLE;
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      default: begin
        txd_nxt_s      = 1'b1;
        tx_state_nxt_s = TX_IDLE;
      end
    endcase
  end

  // TX state register.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      txd_r      <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      tx_bit_r   <= tx_bit_nxt_s;
      tx_shift_r <= tx_shift_nxt_s;
      txd_r      <= txd_nxt_s;
    end
  end

  // RX next-state: sample mid-bit on the synchronised line.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_cnt_nxt_s   = rx_cnt_r;
    rx_bit_nxt_s   = rx_bit_r;
    rx_shift_nxt_s = rx_shift_r;
    rx_push_s      = 1'b0;
    frame_set_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rxd_prev_r && !rxd_sync_r) begin
          rx_cnt_nxt_s   = half_s;
          rx_state_nxt_s = RX_START;
        end else begin
          rx_state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == 16'd0) begin
          if (rxd_sync_r) begin
            rx_state_nxt_s = RX_IDLE;
          end else begin
            rx_cnt_nxt_s   = div_eff_s;
            rx_bit_nxt_s   = 3'd0;
            rx_state_nxt_s = RX_DATA;
          end
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == 16'd0) begin
          rx_cnt_nxt_s   = div_eff_s;
          rx_shift_nxt_s = {rxd_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_nxt_s = RX_STOP;
          end else begin
            rx_bit_nxt_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == 16'd0) begin
          if (rxd_sync_r) begin
            rx_push_s      = 1'b1;
            rx_state_nxt_s = RX_IDLE;
          end else begin
            frame_set_s    = 1'b1;
            rx_state_nxt_s = RX_WAIT;
          end
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_WAIT: begin
        if (rxd_sync_r) begin
          rx_state_nxt_s = RX_IDLE;
        end else begin
          rx_state_nxt_s = RX_WAIT;
        end
      end
      default: begin
        rx_state_nxt_s = RX_IDLE;
      end
    endcase
  end

  // RX synchroniser and state register.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      rxd_meta_r <= uart_rxd_i;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
      rx_state_r <= rx_state_nxt_s;
      rx_cnt_r   <= rx_cnt_nxt_s;
      rx_bit_r   <= rx_bit_nxt_s;
      rx_shift_r <= rx_shift_nxt_s;
    end
  end

  assign rx_ovr_set_s = rx_push_s & rx_full_s & ~rd_data_s;
  assign tx_ovf_set_s = wr_data_s & tx_full_s & ~tx_pop_s;

  // Divisor and sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      div_r       <= DIV_RESET;
      rx_ovr_r    <= 1'b0;
      frame_err_r <= 1'b0;
      tx_ovf_r    <= 1'b0;
    end else begin
      if (wr_div_s) begin
        div_r <= io_dout;
      end
      rx_ovr_r    <= (rx_ovr_r    & ~(wr_status_s & io_dout[ST_RX_OVR]))    | rx_ovr_set_s;
      frame_err_r <= (frame_err_r & ~(wr_status_s & io_dout[ST_FRAME_ERR])) | frame_set_s;
      tx_ovf_r    <= (tx_ovf_r    & ~(wr_status_s & io_dout[ST_TX_OVF]))    | tx_ovf_set_s;
    end
  end

  assign tx_idle_s = (tx_state_r == TX_IDLE) & tx_empty_s;
  assign status_s  = {10'd0, tx_ovf_r, frame_err_r, rx_ovr_r, tx_idle_s, tx_full_s, ~rx_empty_s};

  // Read mux; unmapped addresses return zero so the bus can be OR-ed.
  always_comb begin
    io_din = 16'h0000;
    if (sel_data_s) begin
      io_din = {8'h00, (rx_empty_s ? 8'h00 : rx_head_s)};
    end else if (sel_status_s) begin
      io_din = status_s;
    end else if (sel_div_s) begin
      io_din = div_r;
    end else begin
      io_din = 16'h0000;
    end
  end

  assign uart_txd_o = txd_r;
  assign rx_irq_o   = ~rx_empty_s;

endmodule
